// File: rtl/bus_access_sequencer.sv
// bus_access_sequencer: tracks and terminates the current bus master's cycles, with watchdog
module bus_access_sequencer #(
  parameter int TIMEOUT_CLKS  = 64,
  parameter int RECOVERY_CLKS = 1
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       cpuclk_rising,
  input  logic       cpuclk_falling,
  input  logic [1:0] bm_state,
  input  logic       cpu_as_n_in,
  input  logic       z3_fcs_n_in,
  input  logic       z2_as_n_in,
  input  logic       slave_ack_n_in,
  output logic       access_state_idle,
  output logic       access_start,
  output logic [1:0] access_owner,
  output logic       term_n_out,
  output logic       term_n_oe,
  output logic       berr_n_out,
  output logic       berr_n_oe,
  output logic       timeout_flag,
  output logic       owner_mismatch
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, TERM, RECOVER} state_t;
  state_t     state, nxt;
  logic [3:0] meta, sync;
  logic [7:0] wdog;
  logic [3:0] rcnt;
  logic [1:0] sel_src;
  logic       sel_n, ack_n, timeout, rec_done, start, ack_term, to_term;
  logic       unused_falling;
  assign unused_falling = cpuclk_falling;
  // two-flop synchronizers for all asynchronous strobes; bit order {ack, z2, z3, cpu}
  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= {slave_ack_n_in, z2_as_n_in, z3_fcs_n_in, cpu_as_n_in};
      sync <= meta;
    end
  // strobe selection, termination decisions and next-state logic
  always_comb begin
    sel_src  = state == IDLE ? bm_state : access_owner;
    sel_n    = sel_src == 2'd0 ? sync[0] : sel_src == 2'd2 ? sync[1] : sel_src == 2'd3 ? sync[2] : 1'b1;
    ack_n    = sync[3];
    timeout  = wdog >= 8'(TIMEOUT_CLKS);
    rec_done = cpuclk_rising && (rcnt + 4'd1 >= 4'(RECOVERY_CLKS));
    start    = state == IDLE && !sel_n;
    ack_term = state == DATA && !sel_n && !ack_n;
    to_term  = state == DATA && !sel_n && ack_n && timeout;
    nxt      = state;
    case (state)
      IDLE:    nxt = start ? ADDR : IDLE;
      ADDR:    nxt = sel_n ? RECOVER : cpuclk_rising ? DATA : ADDR;
      DATA:    nxt = sel_n ? RECOVER : (ack_term || to_term) ? TERM : DATA;
      TERM:    nxt = sel_n ? RECOVER : TERM;
      RECOVER: nxt = rec_done ? IDLE : RECOVER;
      default: nxt = IDLE;
    endcase
  end
  // state register, counters and registered strobe outputs
  always_ff @(posedge clk100 or posedge reset)
    if (reset) begin
      state             <= IDLE;
      access_state_idle <= 1'b0;
      access_start      <= 1'b0;
      access_owner      <= 2'd0;
      term_n_out        <= 1'b1;
      term_n_oe         <= 1'b0;
      berr_n_out        <= 1'b1;
      berr_n_oe         <= 1'b0;
      timeout_flag      <= 1'b0;
      owner_mismatch    <= 1'b0;
      wdog              <= 8'd0;
      rcnt              <= 4'd0;
    end else begin
      state             <= nxt;
      access_state_idle <= nxt == IDLE && sel_n;
      access_start      <= start;
      if (start) begin
        access_owner <= bm_state;
        wdog         <= 8'd0;
      end else if (state == DATA && cpuclk_rising && wdog != 8'hff) wdog <= wdog + 8'd1;
      rcnt <= state == RECOVER ? rcnt + {3'd0, cpuclk_rising} : 4'd0;
      if (ack_term) begin
        term_n_out <= 1'b0;
        term_n_oe  <= 1'b1;
      end
      if (to_term) begin
        berr_n_out   <= 1'b0;
        berr_n_oe    <= 1'b1;
        timeout_flag <= 1'b1;
      end
      if (state == TERM && sel_n) begin
        term_n_out <= 1'b1;
        berr_n_out <= 1'b1;
      end
      if (state == RECOVER) begin
        term_n_oe <= 1'b0;
        berr_n_oe <= 1'b0;
      end
      if (state != IDLE && bm_state != access_owner) owner_mismatch <= 1'b1;
    end
endmodule

// File: tb/tb_bus_access_sequencer.sv
// tb_bus_access_sequencer: directed checks of the bus access sequencer
module tb_bus_access_sequencer;
  logic       clk100 = 1'b0;
  logic       reset = 1'b0;
  logic       cpuclk_rising = 1'b0, cpuclk_falling = 1'b0;
  logic [1:0] bm_state = 2'd1;
  logic       cpu_as_n_in = 1'b1, z3_fcs_n_in = 1'b1, z2_as_n_in = 1'b1, slave_ack_n_in = 1'b1;
  logic       idle, start, t_out, t_oe, b_out, b_oe, tflag, mism;
  logic [1:0] owner;
  logic       w_idle, w_start, w_t_out, w_t_oe, w_b_out, w_b_oe, w_tflag, w_mism;
  logic [1:0] w_owner;
  int         cmp = 0, err = 0;

  always #5 clk100 = ~clk100;

  bus_access_sequencer #(.TIMEOUT_CLKS(64), .RECOVERY_CLKS(1)) dut (
    .clk100(clk100), .reset(reset), .cpuclk_rising(cpuclk_rising), .cpuclk_falling(cpuclk_falling),
    .bm_state(bm_state), .cpu_as_n_in(cpu_as_n_in), .z3_fcs_n_in(z3_fcs_n_in), .z2_as_n_in(z2_as_n_in),
    .slave_ack_n_in(slave_ack_n_in), .access_state_idle(idle), .access_start(start), .access_owner(owner),
    .term_n_out(t_out), .term_n_oe(t_oe), .berr_n_out(b_out), .berr_n_oe(b_oe),
    .timeout_flag(tflag), .owner_mismatch(mism));

  bus_access_sequencer #(.TIMEOUT_CLKS(4), .RECOVERY_CLKS(1)) dut_w (
    .clk100(clk100), .reset(reset), .cpuclk_rising(cpuclk_rising), .cpuclk_falling(cpuclk_falling),
    .bm_state(bm_state), .cpu_as_n_in(cpu_as_n_in), .z3_fcs_n_in(z3_fcs_n_in), .z2_as_n_in(z2_as_n_in),
    .slave_ack_n_in(slave_ack_n_in), .access_state_idle(w_idle), .access_start(w_start), .access_owner(w_owner),
    .term_n_out(w_t_out), .term_n_oe(w_t_oe), .berr_n_out(w_b_out), .berr_n_oe(w_b_oe),
    .timeout_flag(w_tflag), .owner_mismatch(w_mism));

  task automatic tick(input logic r);
    cpuclk_rising  = r;
    cpuclk_falling = 1'b0;
    @(negedge clk100);
    cpuclk_rising = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic apply_reset(input logic [1:0] bm);
    reset = 1'b1;
    bm_state = bm;
    cpu_as_n_in = 1'b1;
    z3_fcs_n_in = 1'b1;
    z2_as_n_in = 1'b1;
    slave_ack_n_in = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    cmp++; if (idle !== 1'b0) begin err++; $display("FAIL reset_idle: got %0b want 0", idle); end
    cmp++; if (start !== 1'b0) begin err++; $display("FAIL reset_start: got %0b want 0", start); end
    cmp++; if (owner !== 2'd0) begin err++; $display("FAIL reset_owner: got %0d want 0", owner); end
    cmp++; if ({t_out, t_oe, b_out, b_oe} !== 4'b1010) begin err++; $display("FAIL reset_strobes: got %b want 1010", {t_out, t_oe, b_out, b_oe}); end
    cmp++; if ({tflag, mism} !== 2'b00) begin err++; $display("FAIL reset_flags: got %b want 00", {tflag, mism}); end
    @(negedge clk100);
    reset = 1'b0;
    tick(1'b0);
    cmp++; if (idle !== 1'b1) begin err++; $display("FAIL reset_release_idle: got %0b want 1", idle); end
  endtask

  task automatic test_cpu_read;
    apply_reset(2'd0);
    tick(1'b0);
    cmp++; if (idle !== 1'b1) begin err++; $display("FAIL cpu_idle_before: got %0b want 1", idle); end
    cpu_as_n_in = 1'b0;
    ticks(2);
    cmp++; if (start !== 1'b0) begin err++; $display("FAIL cpu_start_early: got %0b want 0", start); end
    tick(1'b0);
    cmp++; if (start !== 1'b1 || idle !== 1'b0) begin err++; $display("FAIL cpu_start: got start=%0b idle=%0b want 1 0", start, idle); end
    cmp++; if (owner !== 2'd0) begin err++; $display("FAIL cpu_owner: got %0d want 0", owner); end
    tick(1'b0);
    cmp++; if (start !== 1'b0) begin err++; $display("FAIL cpu_start_pulse: got %0b want 0", start); end
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin tick(1'b1); tick(1'b0); end
    slave_ack_n_in = 1'b0;
    ticks(2);
    cmp++; if (t_out !== 1'b1) begin err++; $display("FAIL cpu_term_early: got %0b want 1", t_out); end
    tick(1'b0);
    cmp++; if (t_out !== 1'b0 || t_oe !== 1'b1) begin err++; $display("FAIL cpu_term: got out=%0b oe=%0b want 0 1", t_out, t_oe); end
    cmp++; if (b_oe !== 1'b0) begin err++; $display("FAIL cpu_no_berr: got %0b want 0", b_oe); end
    cpu_as_n_in = 1'b1;
    slave_ack_n_in = 1'b1;
    ticks(2);
    cmp++; if (t_out !== 1'b0) begin err++; $display("FAIL cpu_term_hold: got %0b want 0", t_out); end
    tick(1'b0);
    cmp++; if (t_out !== 1'b1 || t_oe !== 1'b1) begin err++; $display("FAIL cpu_term_negate: got out=%0b oe=%0b want 1 1", t_out, t_oe); end
    tick(1'b0);
    cmp++; if (t_oe !== 1'b0 || idle !== 1'b0) begin err++; $display("FAIL cpu_release: got oe=%0b idle=%0b want 0 0", t_oe, idle); end
    tick(1'b1);
    cmp++; if (idle !== 1'b1) begin err++; $display("FAIL cpu_recover_idle: got %0b want 1", idle); end
  endtask

  task automatic test_watchdog;
    apply_reset(2'd2);
    z3_fcs_n_in = 1'b0;
    ticks(3);
    cmp++; if (w_start !== 1'b1 || w_owner !== 2'd2) begin err++; $display("FAIL wd_start: got start=%0b owner=%0d want 1 2", w_start, w_owner); end
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    cmp++; if (w_b_out !== 1'b1) begin err++; $display("FAIL wd_berr_early: got %0b want 1", w_b_out); end
    tick(1'b0);
    cmp++; if (w_b_out !== 1'b0 || w_b_oe !== 1'b1 || w_tflag !== 1'b1) begin err++; $display("FAIL wd_berr: got out=%0b oe=%0b flag=%0b want 0 1 1", w_b_out, w_b_oe, w_tflag); end
    cmp++; if (w_t_oe !== 1'b0) begin err++; $display("FAIL wd_no_term: got %0b want 0", w_t_oe); end
    cmp++; if (b_oe !== 1'b0 || tflag !== 1'b0) begin err++; $display("FAIL wd_long_timeout: got oe=%0b flag=%0b want 0 0", b_oe, tflag); end
    z3_fcs_n_in = 1'b1;
    ticks(3);
    cmp++; if (w_b_out !== 1'b1 || w_b_oe !== 1'b1) begin err++; $display("FAIL wd_berr_negate: got out=%0b oe=%0b want 1 1", w_b_out, w_b_oe); end
    tick(1'b0);
    tick(1'b1);
    cmp++; if (w_b_oe !== 1'b0 || w_idle !== 1'b1 || w_tflag !== 1'b1) begin err++; $display("FAIL wd_end: got oe=%0b idle=%0b flag=%0b want 0 1 1", w_b_oe, w_idle, w_tflag); end
  endtask

  task automatic test_abort;
    apply_reset(2'd3);
    z2_as_n_in = 1'b0;
    ticks(3);
    cmp++; if (start !== 1'b1 || owner !== 2'd3) begin err++; $display("FAIL abort_start: got start=%0b owner=%0d want 1 3", start, owner); end
    tick(1'b1);
    tick(1'b0);
    z2_as_n_in = 1'b1;
    ticks(3);
    cmp++; if (t_oe !== 1'b0 || b_oe !== 1'b0 || idle !== 1'b0) begin err++; $display("FAIL abort_recover: got toe=%0b boe=%0b idle=%0b want 0 0 0", t_oe, b_oe, idle); end
    tick(1'b1);
    cmp++; if (idle !== 1'b1 || t_out !== 1'b1 || b_out !== 1'b1) begin err++; $display("FAIL abort_idle: got idle=%0b t=%0b b=%0b want 1 1 1", idle, t_out, b_out); end
  endtask

  task automatic test_coincident;
    apply_reset(2'd2);
    z3_fcs_n_in = 1'b0;
    ticks(3);
    tick(1'b1);
    for (int i = 0; i < 2; i++) tick(1'b1);
    slave_ack_n_in = 1'b0;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    cmp++; if (w_t_out !== 1'b0 || w_t_oe !== 1'b1) begin err++; $display("FAIL coin_term: got out=%0b oe=%0b want 0 1", w_t_out, w_t_oe); end
    cmp++; if (w_b_oe !== 1'b0 || w_tflag !== 1'b0) begin err++; $display("FAIL coin_no_berr: got oe=%0b flag=%0b want 0 0", w_b_oe, w_tflag); end
    z3_fcs_n_in = 1'b1;
    slave_ack_n_in = 1'b1;
    ticks(4);
    tick(1'b1);
    cmp++; if (w_idle !== 1'b1 || w_tflag !== 1'b0) begin err++; $display("FAIL coin_end: got idle=%0b flag=%0b want 1 0", w_idle, w_tflag); end
  endtask

  task automatic test_owner_mismatch;
    apply_reset(2'd0);
    cpu_as_n_in = 1'b0;
    ticks(3);
    tick(1'b1);
    cmp++; if (mism !== 1'b0) begin err++; $display("FAIL mism_before: got %0b want 0", mism); end
    bm_state = 2'd2;
    tick(1'b0);
    cmp++; if (mism !== 1'b1) begin err++; $display("FAIL mism_set: got %0b want 1", mism); end
    slave_ack_n_in = 1'b0;
    ticks(3);
    cmp++; if (t_out !== 1'b0 || t_oe !== 1'b1) begin err++; $display("FAIL mism_term: got out=%0b oe=%0b want 0 1", t_out, t_oe); end
    cpu_as_n_in = 1'b1;
    slave_ack_n_in = 1'b1;
    ticks(3);
    cmp++; if (t_out !== 1'b1 || t_oe !== 1'b1) begin err++; $display("FAIL mism_negate: got out=%0b oe=%0b want 1 1", t_out, t_oe); end
    tick(1'b0);
    tick(1'b1);
    cmp++; if (idle !== 1'b1 || mism !== 1'b1 || owner !== 2'd0) begin err++; $display("FAIL mism_end: got idle=%0b mism=%0b owner=%0d want 1 1 0", idle, mism, owner); end
  endtask

  task automatic test_reset_mid_term;
    apply_reset(2'd0);
    cpu_as_n_in = 1'b0;
    ticks(3);
    tick(1'b1);
    slave_ack_n_in = 1'b0;
    ticks(3);
    cmp++; if (t_oe !== 1'b1) begin err++; $display("FAIL rmt_in_term: got %0b want 1", t_oe); end
    #2 reset = 1'b1;
    #1;
    cmp++; if (t_oe !== 1'b0 || t_out !== 1'b1 || idle !== 1'b0) begin err++; $display("FAIL rmt_async: got oe=%0b out=%0b idle=%0b want 0 1 0", t_oe, t_out, idle); end
    cpu_as_n_in = 1'b1;
    slave_ack_n_in = 1'b1;
    @(negedge clk100);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b0);
    cmp++; if (idle !== 1'b1 || start !== 1'b0) begin err++; $display("FAIL rmt_release: got idle=%0b start=%0b want 1 0", idle, start); end
    ticks(4);
    cmp++; if (start !== 1'b0 || t_oe !== 1'b0) begin err++; $display("FAIL rmt_quiet: got start=%0b oe=%0b want 0 0", start, t_oe); end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_watchdog;
    test_abort;
    test_coincident;
    test_owner_mismatch;
    test_reset_mid_term;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/bus_access_sequencer.md
# bus_access_sequencer

Tracks every bus cycle run by the current bus master and terminates it toward that master. Sits directly downstream of the bus arbiter: it consumes `bm_state` (owner: CPU, Zorro III DMA, Zorro II DMA) and produces `access_state_idle`, which the arbiter requires before transferring or returning bus mastery. The block also drives the termination (DTACK-style) and bus-error strobes, with a watchdog for unanswered cycles.

## Interface
- `TIMEOUT_CLKS`, 64: `cpuclk_rising` edges in DATA before the watchdog fires; legal range 2..255.
- `RECOVERY_CLKS`, 1: `cpuclk_rising` edges spent in RECOVER after a cycle ends; legal range 1..15.
- `clk100` input 1: system clock, 100 MHz; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; all registers to reset values.
- `cpuclk_rising` input 1: one-`clk100` pulse at CPU clock rising edge.
- `cpuclk_falling` input 1: one-`clk100` pulse at CPU clock falling edge.
- `bm_state` input 2: bus owner; 0 CPU, 2 Z3, 3 Z2, 1 none.
- `cpu_as_n_in` input 1: CPU address strobe, asynchronous.
- `z3_fcs_n_in` input 1: Zorro III full cycle strobe, asynchronous.
- `z2_as_n_in` input 1: Zorro II DMA address strobe, asynchronous.
- `slave_ack_n_in` input 1: target acknowledge, asynchronous, active-low.
- `access_state_idle` output 1: no cycle in progress and selected strobe negated.
- `access_start` output 1: one-clock pulse when a cycle is accepted.
- `access_owner` output 2: `bm_state` latched at `access_start`.
- `term_n_out`, `term_n_oe` output 1 each: termination strobe, tri-state style.
- `berr_n_out`, `berr_n_oe` output 1 each: bus error strobe, tri-state style.
- `timeout_flag` output 1: sticky; set on watchdog expiry, cleared only by reset.
- `owner_mismatch` output 1: sticky; `bm_state` changed while not IDLE.

## Operation
- Each async input passes through a 2-flop synchronizer; stage 1 output (`*_sync[1]`) is used everywhere.
- Selected strobe `sel_n`: `bm_state` 0 -> CPU AS, 2 -> Z3 FCS, 3 -> Z2 AS, 1 -> constant 1 (never starts a cycle). Selection uses live `bm_state` in IDLE, `access_owner` otherwise.
- States: IDLE, ADDR, DATA, TERM, RECOVER.
- IDLE: `sel_n` low -> ADDR, pulse `access_start`, latch `access_owner`, clear watchdog counter.
- ADDR: `sel_n` high -> RECOVER (aborted, no termination); else `cpuclk_rising` -> DATA.
- DATA: priority order: `sel_n` high -> RECOVER; ack low -> TERM with `term_n_out`=0, `term_n_oe`=1; counter reaches `TIMEOUT_CLKS` -> TERM with `berr_n_out`=0, `berr_n_oe`=1, `timeout_flag` set. Counter increments on each `cpuclk_rising` in DATA; width 8 bits, saturating.
- TERM: hold strobes until `sel_n` high; then drive the asserted strobe to 1 (oe still 1) and go to RECOVER.
- RECOVER: first clock releases `term_n_oe` and `berr_n_oe` to 0. Counts `RECOVERY_CLKS` `cpuclk_rising` edges, then -> IDLE.
- `access_state_idle` is registered: 1 when the next state is IDLE and `sel_n` is high.
- `bm_state` differing from `access_owner` outside IDLE sets `owner_mismatch`; the sequence still completes on the latched owner.
- Reset values: `access_state_idle` 0, `access_start` 0, `access_owner` 0, `term_n_out` 1, `term_n_oe` 0, `berr_n_out` 1, `berr_n_oe` 0, `timeout_flag` 0, `owner_mismatch` 0, state IDLE, synchronizers all 1.

## Timing
- Pin strobe fall -> `sync[1]` low after 2 `clk100` edges -> `access_start` and `access_state_idle`=0 on the next edge (3-clock latency).
- Ack -> `term_n_out` low: 2 synchronizer clocks plus 1 clock when in DATA.
- Term/berr negated (driven high) 1 clock after `sel_n` sync goes high; oe released 1 clock later.
- Minimum cycle-to-cycle spacing: RECOVER plus `RECOVERY_CLKS` CPU rising edges.
- Ack and timeout on the same clock: ack wins; no berr, no flag.
- Strobe negation and ack on the same clock in DATA: abort wins (no termination).
- `reset` asserted mid-cycle: outputs go to reset values immediately (asynchronous). After `reset` deasserts, state is IDLE and `access_state_idle` becomes 1 once `sel_n` sync reads high.

## Test plan
- CPU read: `bm_state`=0, AS low, ack low 5 CPU clocks later -> `access_start` 1 pulse, `access_owner`=0, `term_n_out`=0/oe=1, released after AS high, `access_state_idle`=1 after 1 recovery edge.
- Watchdog: `bm_state`=2, FCS low, no ack, `TIMEOUT_CLKS`=4 -> `berr_n_out`=0 after 4th `cpuclk_rising` in DATA, `timeout_flag`=1 sticky.
- Abort: `bm_state`=3, Z2 AS low for 1 CPU clock then high, no ack -> no term/berr, RECOVER, then IDLE.
- Ack and timeout coincident on the same clock -> term only, `timeout_flag` stays 0.
- `bm_state` 0->2 during DATA -> `owner_mismatch`=1, cycle terminates via CPU AS.
- Reset mid-TERM -> `term_n_oe`=0, `access_state_idle`=0 at once; after release with strobes high, `access_state_idle`=1 and no `access_start`.
